mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's registered ALU result `rz` (used as the effective address) and store operand `rm`.
- Performs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack data-memory port, and forwards non-memory results unchanged.
- Produces the registered write-back value `ry`, plus stall and exception flags for the pipeline controller.

---
 rtl/mem_access.sv | 173 +++++++++++++++++
 tb/tb_mem_access.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues RISC-V byte/half/word loads and stores over a
// req/ack data-memory port, forwards non-memory results, and reports misalignment and
// bus timeouts to the pipeline controller.
module mem_access #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] rz,
    input  logic [31:0] rm,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] ry,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_t;

    state_t        state;
    logic [TW-1:0] cnt;
    logic [2:0]    op_q;
    logic [1:0]    off_q;

    logic          is_mem;
    logic          op_legal;
    logic          aligned;
    logic          access_ok;
    logic          timeout_hit;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   load_val;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    // Decode the incoming operation: legality, alignment, byte enables and write data.
    always_comb begin
        is_mem = mem_read | mem_write;

        unique case (mem_op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase

        unique case (mem_op)
            3'b001, 3'b101: aligned = ~rz[0];
            3'b010:         aligned = (rz[1:0] == 2'b00);
            default:        aligned = 1'b1;
        endcase

        access_ok = valid_in & is_mem & op_legal & aligned;

        unique case (mem_op)
            3'b000, 3'b100: begin
                be_next    = 4'b0001 << rz[1:0];
                wdata_next = {4{rm[7:0]}};
            end
            3'b001, 3'b101: begin
                be_next    = 4'b0011 << rz[1:0];
                wdata_next = {2{rm[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = rm;
            end
        endcase
    end

    // Extract and extend the load result using the offset captured at request time.
    always_comb begin
        byte_sel = dmem_rdata[8*off_q +: 8];
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (op_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    // Stall while a legal access is being launched or is still outstanding; it drops in
    // the cycle whose closing edge completes the access (ack or timeout).
    always_comb begin
        timeout_hit = (cnt == TW'(TIMEOUT - 1));
        if (state == StIdle) begin
            stall = access_ok;
        end else begin
            stall = ~(dmem_ack | timeout_hit);
        end
    end

    // Stage FSM with registered write-back, flags and memory request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            op_q         <= 3'b000;
            off_q        <= 2'b00;
            ry           <= 32'h0;
            valid_out    <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_be      <= 4'h0;
            dmem_wdata   <= 32'h0;
        end else begin
            valid_out    <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (valid_in) begin
                        if (!is_mem) begin
                            ry        <= rz;
                            valid_out <= 1'b1;
                        end else if (!(op_legal && aligned)) begin
                            ry           <= 32'h0;
                            misalign_exc <= 1'b1;
                            valid_out    <= 1'b1;
                        end else begin
                            state      <= StBusy;
                            cnt        <= '0;
                            op_q       <= mem_op;
                            off_q      <= rz[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {rz[31:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                        end
                    end
                end
                StBusy: begin
                    if (dmem_ack) begin
                        // Ack takes priority over a coincident timeout.
                        state     <= StIdle;
                        dmem_req  <= 1'b0;
                        valid_out <= 1'b1;
                        ry        <= dmem_we ? 32'h0 : load_val;
                    end else if (timeout_hit) begin
                        state     <= StIdle;
                        dmem_req  <= 1'b0;
                        valid_out <= 1'b1;
                        bus_err   <= 1'b1;
                        ry        <= 32'h0;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access. Each operation's expected cycle-by-cycle
// behaviour is derived from the access rules and held in exp_* variables; a single
// compare process checks the DUT against them every cycle.
module tb_mem_access;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] rz;
    logic [31:0] rm;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic        stall;
    logic        valid_out;
    logic [31:0] ry;
    logic        misalign_exc;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    mem_access #(.TIMEOUT(16), .TW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .rz           (rz),
        .rm           (rm),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_op       (mem_op),
        .stall        (stall),
        .valid_out    (valid_out),
        .ry           (ry),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for the current cycle.
    bit          chk_en;
    bit          e_zero;
    bit          e_stall, e_vo, e_mis, e_berr, e_req, e_we;
    logic [31:0] e_ry, e_addr, e_wdata;
    logic [3:0]  e_be;

    int          vectors;
    int          miscompares;
    int          req_cycles;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int size_of(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal_f(input logic [2:0] op, input logic [31:0] a);
        case (op)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return a[0] == 1'b0;
            3'b010:         return a[1:0] == 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] op, input logic [1:0] off);
        int n;
        int mask;
        n = size_of(op);
        if (n == 4) return 4'hF;
        mask = (1 << n) - 1;
        return 4'(mask << off);
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] op, input logic [31:0] d);
        int n;
        n = size_of(op);
        if (n == 1) return {4{d[7:0]}};
        if (n == 2) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = size_of(op);
        v = rd >> (int'(off) * 8);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (dmem_req) begin
                req_cycles++;
                cap_addr  = dmem_addr;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
                cap_we    = dmem_we;
            end
            if (chk_en) begin
                check("stall", 32'(stall), 32'(e_stall));
                check("valid_out", 32'(valid_out), 32'(e_vo));
                check("ry", ry, e_ry);
                check("misalign_exc", 32'(misalign_exc), 32'(e_mis));
                check("bus_err", 32'(bus_err), 32'(e_berr));
                check("dmem_req", 32'(dmem_req), 32'(e_req));
                if (e_req) begin
                    check("dmem_we", 32'(dmem_we), 32'(e_we));
                    check("dmem_addr", dmem_addr, e_addr);
                    check("dmem_be", 32'(dmem_be), 32'(e_be));
                    check("dmem_wdata", dmem_wdata, e_wdata);
                end
                if (e_zero) begin
                    check("zero_we", 32'(dmem_we), 32'h0);
                    check("zero_addr", dmem_addr, 32'h0);
                    check("zero_be", 32'(dmem_be), 32'h0);
                    check("zero_wdata", dmem_wdata, 32'h0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_cycle();
        @(negedge clk);
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dmem_ack  = 1'b0;
        e_stall = 0; e_vo = 0; e_mis = 0; e_berr = 0; e_req = 0;
    endtask

    // Drive one operation; lat is the busy cycle (1-based) carrying the ack, 0 = never.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] rdata);
        bit mem;
        bit ok;
        bit acked;
        bit done;
        int i;
        @(negedge clk);
        e_zero    = 0;
        valid_in  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        mem_op    = op;
        rz        = a;
        rm        = d;
        dmem_ack  = 1'b0;
        mem       = rd | wr;
        ok        = legal_f(op, a);
        e_vo = 0; e_mis = 0; e_berr = 0; e_req = 0;
        e_stall   = mem && ok;
        if (!mem || !ok) begin
            @(negedge clk);
            valid_in = 1'b0;
            dmem_ack = 1'($urandom_range(0, 1));
            e_stall  = 0;
            e_vo     = 1;
            e_mis    = mem;
            e_ry     = mem ? 32'h0 : a;
        end else begin
            i     = 0;
            done  = 0;
            acked = 0;
            while (!done) begin
                @(negedge clk);
                // Inputs are don't-care while busy; scramble them.
                valid_in   = 1'($urandom_range(0, 1));
                rz         = $urandom;
                rm         = $urandom;
                mem_op     = 3'($urandom_range(0, 7));
                e_req      = 1;
                e_we       = wr;
                e_addr     = {a[31:2], 2'b00};
                e_be       = be_f(op, a[1:0]);
                e_wdata    = wdata_f(op, d);
                e_vo       = 0;
                e_mis      = 0;
                acked      = (lat != 0) && (i == lat - 1);
                dmem_ack   = acked;
                dmem_rdata = acked ? rdata : $urandom;
                e_stall    = !(acked || i == TIMEOUT - 1);
                done       = acked || (i == TIMEOUT - 1);
                i++;
            end
            @(negedge clk);
            valid_in   = 1'b0;
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            e_req      = 0;
            e_stall    = 0;
            e_vo       = 1;
            e_berr     = !acked;
            e_ry       = acked ? (wr ? 32'h0 : load_f(op, a[1:0], rdata)) : 32'h0;
        end
    endtask

    task automatic reset_mid_access();
        @(negedge clk);
        e_zero = 0;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op = 3'b010;
        rz = 32'h0000_4000; rm = 32'h0; dmem_ack = 1'b0;
        e_vo = 0; e_mis = 0; e_berr = 0; e_req = 0; e_stall = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            e_req = 1; e_we = 0; e_addr = 32'h0000_4000; e_be = 4'hF; e_wdata = 32'h0;
            e_stall = 1;
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        e_req = 0; e_stall = 0; e_vo = 0; e_ry = 32'h0; e_zero = 1;
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    initial begin
        bit rd, wr;
        int kind, lat;
        logic [2:0]  op;
        logic [31:0] a;
        vectors = 0; miscompares = 0; req_cycles = 0;
        chk_en = 0; e_zero = 1;
        rst = 1'b1; valid_in = 1'b0; rz = 32'h0; rm = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; mem_op = 3'b000;
        dmem_rdata = 32'h0; dmem_ack = 1'b0;
        e_stall = 0; e_vo = 0; e_mis = 0; e_berr = 0; e_req = 0; e_we = 0;
        e_ry = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // Forward
        do_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 0, 32'h0);
        #3 check("lit_fwd_ry", ry, 32'h1234_5678);
        idle_cycle();

        // LB sign-extension, ack in second busy cycle
        do_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80AA_BBCC);
        #3 check("lit_lb_ry", ry, 32'hFFFF_FF80);
        check("lit_lb_addr", cap_addr, 32'h0000_1000);
        check("lit_lb_be", 32'(cap_be), 32'h8);
        idle_cycle();

        // SH
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'h0);
        #3 check("lit_sh_ry", ry, 32'h0);
        check("lit_sh_we", 32'(cap_we), 32'h1);
        check("lit_sh_be", 32'(cap_be), 32'hC);
        check("lit_sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        idle_cycle();

        // Misaligned LW
        req_cycles = 0;
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1, 32'h0);
        #3 check("lit_mis_exc", 32'(misalign_exc), 32'h1);
        check("lit_mis_req_cycles", 32'(req_cycles), 32'h0);
        idle_cycle();

        // Timeout
        req_cycles = 0;
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0);
        #3 check("lit_to_req_cycles", 32'(req_cycles), 32'd16);
        check("lit_to_bus_err", 32'(bus_err), 32'h1);
        idle_cycle();

        // Reset mid-access with a late ack
        reset_mid_access();
        idle_cycle();

        // Randomized operations, back to back or with idle gaps
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind == 1);
            wr   = (kind == 2);
            if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 4))
                    0:       op = 3'b000;
                    1:       op = 3'b001;
                    2:       op = 3'b010;
                    3:       op = 3'b100;
                    default: op = 3'b101;
                endcase
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            case ($urandom_range(0, 15))
                0:       lat = 0;
                1:       lat = TIMEOUT;
                2:       lat = TIMEOUT + 3;
                default: lat = $urandom_range(1, 5);
            endcase
            do_op(rd, wr, op, a, $urandom, lat, $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
